// File: rtl/spi_rx_word_fifo.sv
// Word FIFO between the SPI slave receiver and a valid/ready consumer.
// Tracks fill level, a sticky overflow flag and a saturating drop count.
module spi_rx_word_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_RX_DV,
  input  logic [63:0]      i_RX_64Bit,
  input  logic             i_Flush,
  input  logic             i_Clr_Ovf,
  output logic             o_Valid,
  output logic [63:0]      o_Data,
  input  logic             i_Ready,
  output logic [LW-1:0]    o_Level,
  output logic             o_Full,
  output logic             o_Overflow,
  output logic [CNT_W-1:0] o_Drop_Count
);

  logic [63:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_ovf;
  logic [CNT_W-1:0] r_drops;

  logic w_valid;
  logic w_full;
  logic w_rd;
  logic w_wr;
  logic w_drop;

  assign w_valid = (r_level != '0);
  assign w_full  = (r_level == LW'(DEPTH));
  assign w_rd    = w_valid & i_Ready;
  // a same-cycle read frees the slot, so a full FIFO still accepts
  assign w_wr    = i_RX_DV & (~w_full | w_rd);
  assign w_drop  = i_RX_DV & w_full & ~w_rd & ~i_Flush;

  always_ff @(posedge i_Clk) begin
    if (w_wr && !i_Flush && !i_Rst)
      r_mem[r_wr_ptr] <= i_RX_64Bit;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst || i_Flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case (1'b1)
        (w_wr & ~w_rd): r_level <= r_level + 1'b1;
        (w_rd & ~w_wr): r_level <= r_level - 1'b1;
        default:        r_level <= r_level;
      endcase
    end
  end

  // a drop in the clear cycle wins over the clear
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_ovf   <= 1'b0;
      r_drops <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (i_Clr_Ovf)
        r_drops <= CNT_W'(1);
      else if (r_drops != '1)
        r_drops <= r_drops + 1'b1;
    end else if (i_Clr_Ovf) begin
      r_ovf   <= 1'b0;
      r_drops <= '0;
    end
  end

  assign o_Valid      = w_valid;
  assign o_Data       = w_valid ? r_mem[r_rd_ptr] : 64'd0;
  assign o_Level      = r_level;
  assign o_Full       = w_full;
  assign o_Overflow   = r_ovf;
  assign o_Drop_Count = r_drops;

endmodule

// File: tb/tb_spi_rx_word_fifo.sv
// Bench for spi_rx_word_fifo: directed steps plus random traffic,
// every cycle compared against a queue-based reference.
module tb_spi_rx_word_fifo;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             dv = 1'b0;
  logic [63:0]      w = '0;
  logic             fl = 1'b0;
  logic             clr = 1'b0;
  logic             rdy = 1'b0;
  logic             o_Valid;
  logic [63:0]      o_Data;
  logic [3:0]       o_Level;
  logic             o_Full;
  logic             o_Overflow;
  logic [CNT_W-1:0] o_Drop_Count;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] q[$];
  logic        m_ovf = 1'b0;
  int          m_cnt = 0;

  spi_rx_word_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .i_RX_DV(dv),
    .i_RX_64Bit(w),
    .i_Flush(fl),
    .i_Clr_Ovf(clr),
    .o_Valid(o_Valid),
    .o_Data(o_Data),
    .i_Ready(rdy),
    .o_Level(o_Level),
    .o_Full(o_Full),
    .o_Overflow(o_Overflow),
    .o_Drop_Count(o_Drop_Count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [63:0] head;
    head = (q.size() != 0) ? q[0] : 64'd0;
    chk("valid", 64'(o_Valid), 64'(q.size() != 0));
    chk("data", o_Data, head);
    chk("level", 64'(o_Level), 64'(q.size()));
    chk("full", 64'(o_Full), 64'(q.size() == DEPTH));
    chk("ovf", 64'(o_Overflow), 64'(m_ovf));
    chk("drops", 64'(o_Drop_Count), 64'(m_cnt));
  endtask

  task automatic step(input logic d, input logic [63:0] wd,
                      input logic r, input logic f = 1'b0,
                      input logic c = 1'b0, input logic rs = 1'b0);
    bit rd;
    bit full;
    dv = d; w = wd; rdy = r; fl = f; clr = c; rst = rs;
    rd   = (q.size() != 0) && r;
    full = (q.size() == DEPTH);
    @(posedge clk);
    if (rs) begin
      q.delete();
      m_ovf = 1'b0;
      m_cnt = 0;
    end else begin
      if (c) begin
        m_ovf = 1'b0;
        m_cnt = 0;
      end
      if (f) begin
        q.delete();
      end else begin
        if (rd)
          void'(q.pop_front());
        if (d) begin
          if (!full || rd) begin
            q.push_back(wd);
          end else begin
            m_ovf = 1'b1;
            if (m_cnt < CMAX)
              m_cnt++;
          end
        end
      end
    end
    @(negedge clk);
    dv = 1'b0; rdy = 1'b0; fl = 1'b0; clr = 1'b0; rst = 1'b0;
    check_all();
  endtask

  initial begin
    logic [63:0] last;
    @(negedge clk);
    step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_data", o_Data, 64'd0);
    chk("rst_valid", 64'(o_Valid), 64'd0);

    step(1'b1, 64'h0123456789ABCDEF, 1'b0);
    chk("single_data", o_Data, 64'h0123456789ABCDEF);
    chk("single_level", 64'(o_Level), 64'd1);
    for (int i = 0; i < 10; i++) step(1'b0, 64'd0, 1'b0);
    chk("single_hold", o_Data, 64'h0123456789ABCDEF);
    step(1'b0, 64'd0, 1'b1);
    chk("single_gone", 64'(o_Valid), 64'd0);

    for (int i = 1; i <= 8; i++) step(1'b1, 64'(i), 1'b0);
    chk("fill_full", 64'(o_Full), 64'd1);
    for (int i = 0; i < 9; i++) step(1'b0, 64'd0, 1'b1);
    chk("drain_empty", 64'(o_Valid), 64'd0);

    for (int i = 1; i <= 8; i++) step(1'b1, 64'(i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 64'(100 + i), 1'b0);
    chk("ovf_set", 64'(o_Overflow), 64'd1);
    chk("drop3", 64'(o_Drop_Count), 64'd3);
    step(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    chk("clr_cnt", 64'(o_Drop_Count), 64'd0);

    step(1'b1, 64'd9, 1'b1);
    chk("rw_full_level", 64'(o_Level), 64'd8);
    chk("rw_full_head", o_Data, 64'd2);
    last = 64'd0;
    for (int i = 0; i < 8; i++) begin
      last = o_Data;
      step(1'b0, 64'd0, 1'b1);
    end
    chk("tail9", last, 64'd9);

    step(1'b1, 64'd1000, 1'b0);
    for (int i = 1; i < 20; i++) step(1'b1, 64'(1000 + i), 1'b1);
    step(1'b1, 64'd2000, 1'b0);
    step(1'b1, 64'd2001, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 64'd0, 1'b1);

    for (int i = 0; i < 8; i++) step(1'b1, 64'(50 + i), 1'b0);
    step(1'b1, 64'd77, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 64'd0, 1'b1);
    chk("lvl5", 64'(o_Level), 64'd5);
    step(1'b1, 64'd88, 1'b0, 1'b1);
    chk("flush_lvl", 64'(o_Level), 64'd0);
    chk("flush_ovf", 64'(o_Overflow), 64'd1);

    for (int i = 0; i < 3; i++) step(1'b1, 64'(300 + i), 1'b1);
    step(1'b1, 64'd400, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_mid_lvl", 64'(o_Level), 64'd0);
    chk("rst_mid_ovf", 64'(o_Overflow), 64'd0);

    for (int i = 0; i < 8; i++) step(1'b1, 64'(i), 1'b0);
    for (int i = 0; i < 18; i++) step(1'b1, 64'd5, 1'b0);
    chk("sat", 64'(o_Drop_Count), 64'(CMAX));
    step(1'b1, 64'd6, 1'b0, 1'b0, 1'b1);
    chk("clr_drop_cnt", 64'(o_Drop_Count), 64'd1);
    chk("clr_drop_ovf", 64'(o_Overflow), 64'd1);
    step(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 1)), {$urandom, $urandom},
           1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 127) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
